// File: rtl/sudoku_stream_checker.sv
// sudoku_stream_checker: streams an N x N grid row-major and reports row/column/box/range/clue violations
module sudoku_stream_checker #(
  parameter int BOX = 3,
  parameter int DW = 5,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cell_valid,
  output logic             cell_ready,
  input  logic [DW-1:0]    cell_value,
  input  logic             cell_given,
  input  logic [DW-1:0]    clue_value,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_ok,
  output logic [2:0]       err_code,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] num_correct,
  output logic [CNT_W-1:0] num_wrong,
  output logic [31:0]      cycles
);
  localparam int N = BOX * BOX;
  localparam int AW = $clog2(N);
  localparam int BW = $clog2(BOX);
  typedef enum logic [1:0] {CLEAR, COLLECT, REPORT} state_t;
  state_t state;
  logic [N-1:0] row_m [N];
  logic [N-1:0] col_m [N];
  logic [N-1:0] box_m [N];
  logic [AW-1:0] r, c, band, stack, b;
  logic [BW-1:0] col_in_box, row_in_box;
  logic [N-1:0] onehot;
  logic in_range, dup, mism, accept, last;
  logic [2:0] err_next;
  // Per-cell checks against the masks of the current row, column and box
  always_comb begin
    b = band + stack;
    in_range = cell_value != '0 && cell_value <= DW'(N);
    onehot = in_range ? N'(1) << (cell_value - DW'(1)) : '0;
    dup = |((row_m[r] | col_m[c] | box_m[b]) & onehot);
    mism = cell_given && cell_value != clue_value;
    accept = cell_valid && cell_ready;
    last = r == AW'(N - 1) && c == AW'(N - 1);
    err_next = err_code | {mism, dup, ~in_range};
  end
  // Grid FSM: clear masks, collect cells with incremental box tracking, hold verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cell_ready <= 1'b0;
      result_valid <= 1'b0;
      result_ok <= 1'b0;
      err_code <= '0;
      {r, c, band, stack, col_in_box, row_in_box} <= '0;
      for (int i = 0; i < N; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
    end else if (state == CLEAR) begin
      for (int i = 0; i < N; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
      {r, c, band, stack, col_in_box, row_in_box} <= '0;
      err_code <= '0;
      result_ok <= 1'b0;
      cell_ready <= 1'b1;
      state <= COLLECT;
    end else if (state == COLLECT && accept) begin
      err_code <= err_next;
      row_m[r] <= row_m[r] | onehot;
      col_m[c] <= col_m[c] | onehot;
      box_m[b] <= box_m[b] | onehot;
      if (c == AW'(N - 1)) begin
        c <= '0;
        col_in_box <= '0;
        stack <= '0;
        r <= r + AW'(1);
        row_in_box <= row_in_box == BW'(BOX - 1) ? '0 : row_in_box + BW'(1);
        band <= row_in_box == BW'(BOX - 1) ? band + AW'(BOX) : band;
      end else begin
        c <= c + AW'(1);
        col_in_box <= col_in_box == BW'(BOX - 1) ? '0 : col_in_box + BW'(1);
        stack <= col_in_box == BW'(BOX - 1) ? stack + AW'(1) : stack;
      end
      if (last) begin
        state <= REPORT;
        cell_ready <= 1'b0;
        result_valid <= 1'b1;
        result_ok <= err_next == 3'b000;
      end
    end else if (state == REPORT && result_ready) begin
      result_valid <= 1'b0;
      state <= CLEAR;
    end
  end
  // Saturating pass/fail counters, counted once on the edge that enters REPORT; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_correct <= '0;
      num_wrong <= '0;
    end else if (clear_stats) begin
      num_correct <= '0;
      num_wrong <= '0;
    end else if (accept && last) begin
      num_correct <= num_correct + CNT_W'(err_next == 3'b000 && num_correct != '1);
      num_wrong <= num_wrong + CNT_W'(err_next != 3'b000 && num_wrong != '1);
    end
  end
  // Free-running saturating cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles <= '0;
    else cycles <= cycles + 32'(cycles != '1);
  end
endmodule

// File: tb/tb_sudoku_stream_checker.sv
// tb_sudoku_stream_checker: randomized grids checked against a counting reference model
module tb_sudoku_stream_checker;
  localparam int DW = 5, CW = 10;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  logic v3 = 0, g3 = 0, rr3 = 1, cs3 = 0, rdy3, rv3, ok3;
  logic [DW-1:0] val3 = 0, clue3 = 0;
  logic [2:0] err3;
  logic [CW-1:0] nc3, nw3;
  logic [31:0] cyc3;
  logic v2 = 0, g2 = 0, rr2 = 1, cs2 = 0, rdy2, rv2, ok2;
  logic [DW-1:0] val2 = 0, clue2 = 0;
  logic [2:0] err2;
  logic [CW-1:0] nc2, nw2;
  logic [31:0] cyc2;
  sudoku_stream_checker #(.BOX(3), .DW(DW), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .cell_valid(v3), .cell_ready(rdy3), .cell_value(val3),
    .cell_given(g3), .clue_value(clue3), .result_valid(rv3), .result_ready(rr3),
    .result_ok(ok3), .err_code(err3), .clear_stats(cs3), .num_correct(nc3),
    .num_wrong(nw3), .cycles(cyc3));
  sudoku_stream_checker #(.BOX(2), .DW(DW), .CNT_W(CW)) dut2 (
    .clk(clk), .rst(rst), .cell_valid(v2), .cell_ready(rdy2), .cell_value(val2),
    .cell_given(g2), .clue_value(clue2), .result_valid(rv2), .result_ready(rr2),
    .result_ok(ok2), .err_code(err2), .clear_stats(cs2), .num_correct(nc2),
    .num_wrong(nw2), .cycles(cyc2));
  int checks = 0, errors = 0;
  int grid[81], given[81], clue[81];
  int exp_nc = 0, exp_nw = 0;

  function automatic int sat(int x);
    return x >= 1023 ? 1023 : x + 1;
  endfunction

  function automatic int model_err(int box);
    int n = box * box, e = 0;
    int rc[9][10] = '{default: 0};
    int cc[9][10] = '{default: 0};
    int bx[9][10] = '{default: 0};
    for (int i = 0; i < n * n; i++) begin
      int rr = i / n, cl = i % n, v = grid[i];
      if (v < 1 || v > n) e |= 1;
      else begin
        rc[rr][v]++;
        cc[cl][v]++;
        bx[(rr / box) * box + cl / box][v]++;
      end
      if (given[i] != 0 && clue[i] != v) e |= 4;
    end
    for (int u = 0; u < n; u++)
      for (int v = 1; v <= n; v++)
        if (rc[u][v] > 1 || cc[u][v] > 1 || bx[u][v] > 1) e |= 2;
    return e;
  endfunction

  task automatic make_valid(input int box);
    int n = box * box, p[9], t, j;
    for (int i = 0; i < n; i++) p[i] = i + 1;
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(i, 0); t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int rr = 0; rr < n; rr++)
      for (int cl = 0; cl < n; cl++) begin
        grid[rr * n + cl] = p[(rr * box + rr / box + cl) % n];
        given[rr * n + cl] = 0;
        clue[rr * n + cl] = 0;
      end
  endtask

  task automatic add_clues(input int n, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int i = $urandom_range(n * n - 1, 0);
      given[i] = 1; clue[i] = grid[i];
    end
  endtask

  task automatic stream3(input bit gaps, input int ncells, output bit to, output int t0, output int t1);
    to = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < ncells && !to; i++) begin
      if (gaps && $urandom_range(3, 0) == 0) begin
        v3 = 0; val3 = DW'($urandom); @(posedge clk); #1;
      end
      v3 = 1; val3 = DW'(grid[i]); g3 = given[i][0]; clue3 = DW'(clue[i]);
      for (int k = 0; !rdy3 && k < 50; k++) begin @(posedge clk); #1; end
      if (!rdy3) to = 1;
      else begin
        @(posedge clk); #1;
        if (i == 0) t0 = tick;
        t1 = tick;
      end
    end
    v3 = 0; g3 = 0;
  endtask

  task automatic run_grid3(input bit gaps, output int t0, output int t1);
    int e = model_err(3);
    bit to;
    rr3 = 1;
    stream3(gaps, 81, to, t0, t1);
    if (e == 0) exp_nc = sat(exp_nc); else exp_nw = sat(exp_nw);
    checks++;
    if (to || rv3 !== 1'b1) begin errors++; $display("FAIL result_valid_after_last: got %b timeout=%0d, want 1", rv3, to); end
    checks++;
    if (ok3 !== 1'(e == 0)) begin errors++; $display("FAIL result_ok: got %b, want %0d", ok3, e == 0); end
    checks++;
    if (err3 !== 3'(e)) begin errors++; $display("FAIL err_code: got %b, want %b", err3, 3'(e)); end
    checks++;
    if (nc3 !== CW'(exp_nc) || nw3 !== CW'(exp_nw)) begin
      errors++; $display("FAIL stats: got correct=%0d wrong=%0d, want %0d %0d", nc3, nw3, exp_nc, exp_nw);
    end
    @(posedge clk); #1;
    checks++;
    if (rv3 !== 1'b0) begin errors++; $display("FAIL result_consumed: got %b, want 0", rv3); end
  endtask

  task automatic test_reset;
    checks++;
    if (rdy3 !== 0 || rv3 !== 0 || ok3 !== 0 || err3 !== 0 || nc3 !== 0 || nw3 !== 0 || cyc3 !== 0) begin
      errors++; $display("FAIL reset_values: got rdy=%b rv=%b ok=%b err=%b nc=%0d nw=%0d cyc=%0d, want all 0", rdy3, rv3, ok3, err3, nc3, nw3, cyc3);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    checks++;
    if (cyc3 !== 32'd1 || rdy3 !== 1'b1) begin errors++; $display("FAIL after_reset: got cycles=%0d ready=%b, want 1 1", cyc3, rdy3); end
  endtask

  task automatic test_valid;
    int a, b;
    make_valid(3); add_clues(9, 30); run_grid3(1, a, b);
  endtask

  task automatic test_swap;
    int a, b, t;
    make_valid(3);
    t = grid[0]; grid[0] = grid[1]; grid[1] = t;
    run_grid3(1, a, b);
  endtask

  task automatic test_range;
    int a, b;
    make_valid(3); grid[4 * 9 + 4] = 0; run_grid3(1, a, b);
    make_valid(3); grid[$urandom_range(80, 0)] = 10; run_grid3(1, a, b);
    make_valid(3); grid[$urandom_range(80, 0)] = $urandom_range(31, 10); run_grid3(0, a, b);
  endtask

  task automatic test_clue;
    int a, b, idx = 2 * 9 + 7, old;
    make_valid(3);
    old = grid[idx];
    for (int i = 0; i < 81; i++)
      grid[i] = grid[i] == old ? 3 : grid[i] == 3 ? old : grid[i];
    add_clues(9, 20);
    given[idx] = 1; clue[idx] = 5;
    run_grid3(1, a, b);
  endtask

  task automatic test_stall;
    bit to;
    int a, b;
    make_valid(3); add_clues(9, 10);
    rr3 = 0;
    stream3(1, 81, to, a, b);
    exp_nc = sat(exp_nc);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (to || rdy3 !== 0 || rv3 !== 1 || ok3 !== 1 || err3 !== 0 || nc3 !== CW'(exp_nc)) begin
        errors++; $display("FAIL stall_cycle%0d: got rdy=%b rv=%b ok=%b err=%b nc=%0d, want 0 1 1 000 %0d", k, rdy3, rv3, ok3, err3, nc3, exp_nc);
      end
      v3 = 1; val3 = DW'($urandom);
      @(posedge clk); #1;
    end
    v3 = 0; rr3 = 1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (rv3 !== 0 || nc3 !== CW'(exp_nc)) begin errors++; $display("FAIL stall_release: got rv=%b nc=%0d, want 0 %0d", rv3, nc3, exp_nc); end
  endtask

  task automatic test_back_to_back;
    int a0, a1, b0, b1;
    make_valid(3); run_grid3(0, a0, a1);
    make_valid(3); add_clues(9, 5); run_grid3(0, b0, b1);
    checks++;
    if (b0 - a1 !== 3) begin errors++; $display("FAIL back_to_back_spacing: got %0d, want 3", b0 - a1); end
  endtask

  task automatic test_random;
    int a, b, i, j, t;
    for (int g = 0; g < 8; g++) begin
      make_valid(3); add_clues(9, $urandom_range(40, 0));
      i = $urandom_range(80, 0); j = $urandom_range(80, 0);
      case ($urandom_range(3, 0))
        0: ;
        1: grid[i] = $urandom_range(31, 0);
        2: begin given[i] = 1; clue[i] = grid[i] % 9 + 1; end
        default: begin t = grid[i]; grid[i] = grid[j]; grid[j] = t; end
      endcase
      run_grid3($urandom_range(1, 0) == 1, a, b);
    end
  endtask

  task automatic test_cycles;
    logic [31:0] c0 = cyc3;
    cs3 = 1;
    repeat (10) @(posedge clk);
    #1; cs3 = 0;
    exp_nc = 0; exp_nw = 0;
    checks++;
    if (cyc3 - c0 !== 32'd10) begin errors++; $display("FAIL cycles_delta: got %0d, want 10", cyc3 - c0); end
    checks++;
    if (nc3 !== 0 || nw3 !== 0) begin errors++; $display("FAIL clear_stats: got %0d %0d, want 0 0", nc3, nw3); end
  endtask

  task automatic test_reset_mid;
    bit to;
    int a, b;
    make_valid(3);
    stream3(0, 40, to, a, b);
    v3 = 1; rst = 1; #1;
    checks++;
    if (rdy3 !== 0 || rv3 !== 0 || ok3 !== 0 || err3 !== 0 || nc3 !== 0 || nw3 !== 0 || cyc3 !== 0) begin
      errors++; $display("FAIL mid_reset_values: got rdy=%b rv=%b ok=%b err=%b nc=%0d nw=%0d cyc=%0d, want all 0", rdy3, rv3, ok3, err3, nc3, nw3, cyc3);
    end
    v3 = 0;
    @(negedge clk); rst = 0;
    exp_nc = 0; exp_nw = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rv3 !== 0) begin errors++; $display("FAIL no_verdict_after_abort: got %b, want 0", rv3); end
    end
    make_valid(3); add_clues(9, 30); run_grid3(1, a, b);
  endtask

  task automatic stream2(input bit clr_last, output bit to);
    to = 0;
    for (int i = 0; i < 16 && !to; i++) begin
      v2 = 1; val2 = DW'(grid[i]); g2 = given[i][0]; clue2 = DW'(clue[i]); cs2 = clr_last && i == 15;
      for (int k = 0; !rdy2 && k < 50; k++) begin @(posedge clk); #1; end
      if (!rdy2) to = 1;
      else begin @(posedge clk); #1; end
    end
    v2 = 0; cs2 = 0;
  endtask

  task automatic test_box2;
    bit to;
    int e, enc = 0, enw = 0;
    make_valid(2); add_clues(4, 6);
    e = model_err(2);
    stream2(0, to);
    enc = sat(enc);
    checks++;
    if (to || rv2 !== 1 || ok2 !== 1'(e == 0) || err2 !== 3'(e) || nc2 !== CW'(enc)) begin
      errors++; $display("FAIL box2_valid: got rv=%b ok=%b err=%b nc=%0d, want 1 %0d %b %0d", rv2, ok2, err2, nc2, e == 0, 3'(e), enc);
    end
    @(posedge clk); #1;
    make_valid(2); grid[5] = grid[4];
    e = model_err(2);
    stream2(0, to);
    enw = sat(enw);
    checks++;
    if (to || rv2 !== 1 || ok2 !== 0 || err2 !== 3'(e) || nw2 !== CW'(enw)) begin
      errors++; $display("FAIL box2_dup: got rv=%b ok=%b err=%b nw=%0d, want 1 0 %b %0d", rv2, ok2, err2, nw2, 3'(e), enw);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 1022 && !to; g++) begin
      make_valid(2); stream2(0, to); enc = sat(enc);
      @(posedge clk); #1;
    end
    checks++;
    if (to || nc2 !== CW'(enc) || nc2 !== 10'h3FF) begin errors++; $display("FAIL box2_saturate: got %0d timeout=%0d, want %0d", nc2, to, enc); end
    make_valid(2); stream2(0, to); enc = sat(enc);
    checks++;
    if (to || nc2 !== CW'(enc) || nw2 !== CW'(enw)) begin errors++; $display("FAIL box2_hold: got %0d %0d, want %0d %0d", nc2, nw2, enc, enw); end
    @(posedge clk); #1;
    make_valid(2); stream2(1, to); enc = 0; enw = 0;
    checks++;
    if (to || rv2 !== 1 || ok2 !== 1 || nc2 !== CW'(enc) || nw2 !== CW'(enw)) begin
      errors++; $display("FAIL box2_clear_wins: got rv=%b ok=%b nc=%0d nw=%0d, want 1 1 0 0", rv2, ok2, nc2, nw2);
    end
    @(posedge clk); #1;
    make_valid(2); stream2(0, to); enc = sat(enc);
    checks++;
    if (to || nc2 !== CW'(enc) || nw2 !== CW'(enw)) begin errors++; $display("FAIL box2_after_clear: got %0d %0d, want %0d %0d", nc2, nw2, enc, enw); end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_valid;
    test_swap;
    test_range;
    test_clue;
    test_stall;
    test_back_to_back;
    test_random;
    test_cycles;
    test_reset_mid;
    test_box2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
